reg_status_table: RTL and testbench

Parametrised successor of the dispatch-stage register status table. Holds architectural register data plus a rename tag per register, for an NISSUE-wide dispatch bundle and NWB common-data-bus writeback ports. Adds behaviour the previous table lacked:
- tag-checked unlock
- intra-bundle rename forwarding
- whole-table flush for misprediction recovery
- optional same-cycle writeback bypass
Sits between decode/dispatch and the reservation stations.

---
 rtl/reg_status_table.sv | 120 ++++++++++++
 tb/tb_reg_status_table.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_status_table.sv
`default_nettype none
// ============================================================================
// Module   : reg_status_table
// Purpose  : Dispatch-stage register data/rename-tag table with tag-checked
//            writeback unlock, intra-bundle forwarding and flush.
//            Optional macro REG_STAT_BYPASS_EN: same-cycle writeback bypass.
// Revision : 1.0
// ============================================================================
module reg_status_table #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int AW        = $clog2(REG_COUNT),
    parameter int TAG_W     = 4,
    parameter int NISSUE    = 2,
    parameter int NWB       = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [NISSUE*XLEN-1:0]  imm,
    input  logic [NISSUE-1:0]       en_rx,
    input  logic [NISSUE-1:0]       en_ry,
    input  logic [NISSUE*AW-1:0]    addrx,
    input  logic [NISSUE*AW-1:0]    addry,
    output logic [NISSUE*XLEN-1:0]  datax,
    output logic [NISSUE*XLEN-1:0]  datay,
    output logic [NISSUE*TAG_W-1:0] tagx,
    output logic [NISSUE*TAG_W-1:0] tagy,
    input  logic [NISSUE-1:0]       en_mod,
    input  logic [NISSUE*AW-1:0]    mod_addr,
    input  logic [NISSUE*TAG_W-1:0] mod_tag,
    input  logic [NISSUE-1:0]       en_rw,
    output logic [NISSUE*TAG_W-1:0] tagw,
    input  logic [NWB-1:0]          en_wb,
    input  logic [NWB*AW-1:0]       wb_addr,
    input  logic [NWB*TAG_W-1:0]    wb_tag,
    input  logic [NWB*XLEN-1:0]     wb_data
);

    logic [REG_COUNT-1:0][XLEN-1:0]  r_data;
    logic [REG_COUNT-1:0][TAG_W-1:0] r_tag;

    // Stored tag overridden by the youngest older-slot rename of the same register.
    function automatic logic [TAG_W-1:0] fwd_tag(input int slot, input logic [AW-1:0] a);
        logic [TAG_W-1:0] t;
        t = r_tag[a];
        for (int i = 0; i < NISSUE; i++) begin
            if (i < slot && en_mod[i] && mod_addr[i*AW +: AW] == a && a != '0)
                t = mod_tag[i*TAG_W +: TAG_W];
        end
        return t;
    endfunction

    function automatic logic [XLEN+TAG_W-1:0] read_src(input int slot, input logic en,
                                                       input logic [AW-1:0] a);
        logic [TAG_W-1:0] t;
        logic [XLEN-1:0]  d;
        t = fwd_tag(slot, a);
        d = r_data[a];
`ifdef REG_STAT_BYPASS_EN
        for (int p = NWB-1; p >= 0; p--) begin
            if (en_wb[p] && wb_addr[p*AW +: AW] == a && wb_tag[p*TAG_W +: TAG_W] == t) begin
                d = wb_data[p*XLEN +: XLEN];
                t = '0;
            end
        end
`endif
        if (!en) begin
            d = imm[slot*XLEN +: XLEN];
            t = '0;
        end
        if (a == '0) begin
            d = '0;
            t = '0;
        end
        return {d, t};
    endfunction

    always_comb begin
        datax = '0;
        datay = '0;
        tagx  = '0;
        tagy  = '0;
        tagw  = '0;
        for (int j = 0; j < NISSUE; j++) begin
            {datax[j*XLEN +: XLEN], tagx[j*TAG_W +: TAG_W]} = read_src(j, en_rx[j], addrx[j*AW +: AW]);
            {datay[j*XLEN +: XLEN], tagy[j*TAG_W +: TAG_W]} = read_src(j, en_ry[j], addry[j*AW +: AW]);
            if (en_rw[j])
                tagw[j*TAG_W +: TAG_W] = fwd_tag(j, mod_addr[j*AW +: AW]);
        end
    end

    // Writebacks are applied first (highest port first so port 0 lands last),
    // then renames oldest to youngest so the youngest slot owns the tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_tag  <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_tag <= '0;
            end else begin
                for (int p = NWB-1; p >= 0; p--) begin
                    if (en_wb[p] && wb_addr[p*AW +: AW] != '0 &&
                        r_tag[wb_addr[p*AW +: AW]] == wb_tag[p*TAG_W +: TAG_W]) begin
                        r_data[wb_addr[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
                        r_tag[wb_addr[p*AW +: AW]]  <= '0;
                    end
                end
                for (int i = 0; i < NISSUE; i++) begin
                    if (en_mod[i] && mod_addr[i*AW +: AW] != '0)
                        r_tag[mod_addr[i*AW +: AW]] <= mod_tag[i*TAG_W +: TAG_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_status_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_status_table
// Purpose  : Directed and randomized self-checking bench for reg_status_table.
// Revision : 1.0
// ============================================================================
module tb_reg_status_table;
    localparam int XLEN = 32, REG_COUNT = 32, AW = 5, TAG_W = 4, NISSUE = 2, NWB = 3;

    logic clk = 1'b0, rst = 1'b1, rdy = 1'b1, flush = 1'b0;
    logic [NISSUE*XLEN-1:0]  imm, datax, datay;
    logic [NISSUE-1:0]       en_rx, en_ry, en_mod, en_rw;
    logic [NISSUE*AW-1:0]    addrx, addry, mod_addr;
    logic [NISSUE*TAG_W-1:0] tagx, tagy, mod_tag, tagw;
    logic [NWB-1:0]          en_wb;
    logic [NWB*AW-1:0]       wb_addr;
    logic [NWB*TAG_W-1:0]    wb_tag;
    logic [NWB*XLEN-1:0]     wb_data;

    logic [XLEN-1:0]  m_data [REG_COUNT];
    logic [TAG_W-1:0] m_tag  [REG_COUNT];
    int n_assert = 0, n_fail = 0;

    reg_status_table dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .imm(imm),
        .en_rx(en_rx), .en_ry(en_ry), .addrx(addrx), .addry(addry),
        .datax(datax), .datay(datay), .tagx(tagx), .tagy(tagy),
        .en_mod(en_mod), .mod_addr(mod_addr), .mod_tag(mod_tag),
        .en_rw(en_rw), .tagw(tagw),
        .en_wb(en_wb), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [TAG_W-1:0] ref_eff_tag(input int j, input logic [AW-1:0] a);
        for (int i = j - 1; i >= 0; i--)
            if (en_mod[i] && mod_addr[i*AW +: AW] == a) return mod_tag[i*TAG_W +: TAG_W];
        return m_tag[a];
    endfunction

    task automatic ref_read(input int j, input logic en, input logic [AW-1:0] a,
                            output logic [XLEN-1:0] d, output logic [TAG_W-1:0] t);
        bit hit;
        if (a == 0) begin
            d = 0; t = 0;
        end else if (!en) begin
            d = imm[j*XLEN +: XLEN]; t = 0;
        end else begin
            t = ref_eff_tag(j, a);
            d = m_data[a];
            hit = 0;
`ifdef REG_STAT_BYPASS_EN
            for (int p = 0; p < NWB; p++)
                if (!hit && en_wb[p] && wb_addr[p*AW +: AW] == a && wb_tag[p*TAG_W +: TAG_W] == t) begin
                    d = wb_data[p*XLEN +: XLEN]; t = 0; hit = 1;
                end
`endif
        end
    endtask

    task automatic check_all();
        logic [XLEN-1:0] d;
        logic [TAG_W-1:0] t;
        for (int j = 0; j < NISSUE; j++) begin
            ref_read(j, en_rx[j], addrx[j*AW +: AW], d, t);
            chk($sformatf("datax[%0d]", j), datax[j*XLEN +: XLEN], d);
            chk($sformatf("tagx[%0d]", j), tagx[j*TAG_W +: TAG_W], t);
            ref_read(j, en_ry[j], addry[j*AW +: AW], d, t);
            chk($sformatf("datay[%0d]", j), datay[j*XLEN +: XLEN], d);
            chk($sformatf("tagy[%0d]", j), tagy[j*TAG_W +: TAG_W], t);
            t = (!en_rw[j] || mod_addr[j*AW +: AW] == 0) ? '0 : ref_eff_tag(j, mod_addr[j*AW +: AW]);
            chk($sformatf("tagw[%0d]", j), tagw[j*TAG_W +: TAG_W], t);
        end
    endtask

    // Per-register next state: lowest matching writeback port, then youngest rename.
    task automatic model_step();
        logic [XLEN-1:0]  nd [REG_COUNT];
        logic [TAG_W-1:0] nt [REG_COUNT];
        bit done;
        if (!rdy) return;
        nd = m_data; nt = m_tag;
        for (int r = 1; r < REG_COUNT; r++) begin
            if (flush) begin
                nt[r] = 0;
                continue;
            end
            done = 0;
            for (int p = 0; p < NWB; p++)
                if (!done && en_wb[p] && wb_addr[p*AW +: AW] == r && wb_tag[p*TAG_W +: TAG_W] == m_tag[r]) begin
                    nd[r] = wb_data[p*XLEN +: XLEN]; nt[r] = 0; done = 1;
                end
            for (int i = 0; i < NISSUE; i++)
                if (en_mod[i] && mod_addr[i*AW +: AW] == r) nt[r] = mod_tag[i*TAG_W +: TAG_W];
        end
        m_data = nd; m_tag = nt;
    endtask

    task automatic model_reset();
        for (int r = 0; r < REG_COUNT; r++) begin m_data[r] = 0; m_tag[r] = 0; end
    endtask

    task automatic tick();
        #2;
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1; flush = 0; imm = '0;
        en_rx = '0; en_ry = '0; addrx = '0; addry = '0;
        en_mod = '0; mod_addr = '0; mod_tag = '0; en_rw = '0;
        en_wb = '0; wb_addr = '0; wb_tag = '0; wb_data = '0;
    endtask

    task automatic set_mod(input int s, input logic [AW-1:0] a, input logic [TAG_W-1:0] t);
        en_mod[s] = 1; mod_addr[s*AW +: AW] = a; mod_tag[s*TAG_W +: TAG_W] = t;
    endtask

    task automatic set_wb(input int p, input logic [AW-1:0] a, input logic [TAG_W-1:0] t,
                          input logic [XLEN-1:0] d);
        en_wb[p] = 1; wb_addr[p*AW +: AW] = a; wb_tag[p*TAG_W +: TAG_W] = t; wb_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd_x(input int s, input logic [AW-1:0] a);
        en_rx[s] = 1; addrx[s*AW +: AW] = a;
    endtask

    task automatic peek_x0(input string name, input logic [XLEN-1:0] d, input logic [TAG_W-1:0] t);
        #1;
        chk({name, "_data"}, datax[XLEN-1:0], d);
        chk({name, "_tag"}, tagx[TAG_W-1:0], t);
    endtask

    initial begin
        idle();
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;

        // Tag-checked unlock
        set_mod(0, 5, 3); tick();
        idle(); set_mod(0, 5, 7); tick();
        idle(); set_wb(0, 5, 3, 32'hAAAA); tick();
        idle(); rd_x(0, 5); peek_x0("stale_wb", 32'h0, 4'd7);
        set_wb(0, 5, 7, 32'hBBBB); tick();
        idle(); rd_x(0, 5); peek_x0("unlock", 32'hBBBB, 4'd0);

        // Intra-bundle forwarding and youngest-slot rename
        idle(); set_mod(0, 4, 2); rd_x(1, 4); en_rw[1] = 1; mod_addr[AW +: AW] = 4;
        #1;
        chk("fwd_tagx1", tagx[TAG_W +: TAG_W], 4'd2);
        chk("fwd_tagw1", tagw[TAG_W +: TAG_W], 4'd2);
        tick();
        idle(); set_mod(0, 4, 2); set_mod(1, 4, 5); tick();
        idle(); rd_x(0, 4); peek_x0("youngest", 32'h0, 4'd5);

        // Flush ignores a matching writeback
        idle(); set_wb(0, 1, 0, 32'h55); tick();
        idle(); set_mod(0, 1, 1); set_mod(1, 2, 2); tick();
        idle(); set_mod(0, 3, 3); tick();
        idle(); flush = 1; set_wb(0, 1, 1, 32'h99); tick();
        idle(); rd_x(0, 1); en_ry[0] = 1; addry[AW-1:0] = 2; rd_x(1, 3);
        peek_x0("flush_x1", 32'h55, 4'd0);
        chk("flush_x2_tag", tagy[TAG_W-1:0], 4'd0);
        chk("flush_x3_tag", tagx[TAG_W +: TAG_W], 4'd0);

        // Stall, x0 and disabled read
        idle(); rdy = 0; set_mod(0, 7, 6); set_wb(0, 5, 0, 32'h77); tick();
        idle(); rd_x(0, 5); peek_x0("stall_x5", 32'hBBBB, 4'd0);
        idle(); rd_x(0, 7); peek_x0("stall_x7", 32'h0, 4'd0);
        idle(); set_mod(0, 0, 9); set_wb(0, 0, 0, 32'h33); tick();
        idle(); rd_x(0, 0); peek_x0("x0", 32'h0, 4'd0);
        idle(); addrx[AW-1:0] = 5; imm[XLEN-1:0] = 32'hDEAD; peek_x0("imm", 32'hDEAD, 4'd0);

        // Same-cycle writeback visibility
        idle(); set_mod(0, 6, 4); tick();
        idle(); set_wb(0, 6, 4, 32'h1234); rd_x(0, 6);
`ifdef REG_STAT_BYPASS_EN
        peek_x0("bypass_same", 32'h1234, 4'd0);
`else
        peek_x0("nobypass_same", 32'h0, 4'd4);
`endif
        tick();
        idle(); rd_x(0, 6); peek_x0("wb_next", 32'h1234, 4'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            idle();
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int s = 0; s < NISSUE; s++) begin
                imm[s*XLEN +: XLEN] = $urandom;
                en_rx[s] = $urandom_range(0, 3) != 0;
                en_ry[s] = $urandom_range(0, 3) != 0;
                addrx[s*AW +: AW] = AW'($urandom_range(0, 7));
                addry[s*AW +: AW] = AW'($urandom_range(0, 7));
                en_mod[s] = $urandom_range(0, 1);
                mod_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
                mod_tag[s*TAG_W +: TAG_W] = TAG_W'($urandom_range(1, 15));
                en_rw[s] = $urandom_range(0, 1);
            end
            for (int p = 0; p < NWB; p++) begin
                en_wb[p] = $urandom_range(0, 1);
                wb_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
                wb_tag[p*TAG_W +: TAG_W] = ($urandom_range(0, 1) != 0) ?
                    m_tag[wb_addr[p*AW +: AW]] : TAG_W'($urandom_range(0, 15));
                wb_data[p*XLEN +: XLEN] = $urandom;
            end
            tick();
        end

        // Asynchronous reset with a locked register
        idle(); set_mod(0, 5, 3); tick();
        idle(); rd_x(0, 5);
        #1;
        chk("pre_rst_tag", tagx[TAG_W-1:0], 4'd3);
        rst = 1;
        model_reset();
        peek_x0("async_rst", 32'h0, 4'd0);
        check_all();
        #10;
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
